// File: rtl/csh_dir_nway.sv
// rtl/csh_dir_nway.sv - N-way cache directory: tag compare, per-word valid, tree PLRU, valid-clear sweep, diag read
module csh_dir_nway #(
   parameter int WAYS  = 4,
   parameter int TAG_W = 13,
   parameter int IDX_W = 7,
   parameter int WORDS = 4,
   localparam int WAY_W = $clog2(WAYS),
   localparam int WD_W  = $clog2(WORDS),
   localparam int SETS  = 1 << IDX_W
) (
   input  logic               clk_csh_h,
   input  logic               mr_reset_l,
   input  logic               lookup_h,
   input  logic [IDX_W-1:0]   lookup_idx_h,
   input  logic [TAG_W-1:0]   lookup_tag_h,
   input  logic [WD_W-1:0]    lookup_wd_h,
   input  logic               force_no_match_h,
   input  logic [WAYS-1:0]    force_valid_match_h,
   input  logic               use_wr_en_h,
   input  logic               use_hold_h,
   input  logic               refill_wr_h,
   input  logic [WAY_W-1:0]   refill_way_h,
   input  logic [IDX_W-1:0]   refill_idx_h,
   input  logic [TAG_W-1:0]   refill_tag_h,
   input  logic [WORDS-1:0]   refill_wd_en_h,
   input  logic               val_clr_all_h,
   input  logic               diag_rd_h,
   input  logic [WAY_W-1:0]   diag_way_h,
   input  logic [IDX_W-1:0]   diag_idx_h,
   output logic [WAYS-1:0]    hit_way_h,
   output logic               hit_h,
   output logic               multi_hit_h,
   output logic [WAYS-1:0]    wd_val_h,
   output logic [WAY_W-1:0]   lru_way_h,
   output logic               adr_par_bad_l,
   output logic               sweep_busy_h,
   output logic               wr_drop_h,
   output logic [TAG_W-1:0]   diag_tag_h,
   output logic               diag_par_h,
   output logic [WORDS-1:0]   diag_val_h
);

   typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_sweep_cnt;
   logic [TAG_W-1:0]   r_tag [WAYS][SETS];
   logic               r_par [WAYS][SETS];
   logic [WORDS-1:0]   r_val [WAYS][SETS];
   logic [WAYS-2:0]    r_plru [SETS];

   logic [WAYS-1:0]    w_par_inj;
   logic [WAYS-1:0]    w_any_val, w_par_ok, w_res, w_wd_val;
   logic [WAY_W-1:0]   w_hit_idx, w_free_idx, w_victim;
   logic               w_par_err, w_free, w_hit, w_multi, w_sweep, w_refill_ok, w_lru_upd;

   // Heap-ordered tree: node n (1-based) lives at bit n-1; a 0 bit sends the victim to the lower half.
   function automatic logic [WAY_W-1:0] f_victim(input logic [WAYS-2:0] t);
      int n;
      n = 1;
      for (int l = 0; l < WAY_W; l++) n = 2 * n + int'(t[n-1]);
      return WAY_W'(n - WAYS);
   endfunction

   function automatic logic [WAYS-2:0] f_touch(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] w);
      int n;
      logic [WAYS-2:0] r;
      r = t;
      n = 1;
      for (int l = WAY_W - 1; l >= 0; l--) begin
         r[n-1] = ~w[l];
         n = 2 * n + int'(w[l]);
      end
      return r;
   endfunction

   // Parity corruption hook, driven only by a test harness force.
   assign w_par_inj = '0;

   assign w_sweep      = (r_state == ST_SWEEP);
   assign sweep_busy_h = w_sweep;
   assign w_refill_ok  = refill_wr_h && !w_sweep;
   assign w_hit        = |w_res;
   assign w_multi      = |(w_res & (w_res - WAYS'(1)));
   assign w_lru_upd    = lookup_h && w_hit && use_wr_en_h && !use_hold_h;
   assign w_victim     = f_victim(r_plru[lookup_idx_h]);

   always_comb begin
      w_any_val  = '0;
      w_par_ok   = '0;
      w_res      = '0;
      w_wd_val   = '0;
      w_par_err  = 1'b0;
      w_hit_idx  = '0;
      w_free     = 1'b0;
      w_free_idx = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_any_val[w] = |r_val[w][lookup_idx_h];
         w_par_ok[w]  = ^{r_tag[w][lookup_idx_h], r_par[w][lookup_idx_h]};
         w_wd_val[w]  = r_val[w][lookup_idx_h][lookup_wd_h];
         w_res[w]     = ((r_tag[w][lookup_idx_h] == lookup_tag_h) && w_par_ok[w] && w_any_val[w] && !w_sweep)
                        || force_valid_match_h[w];
         if (w_any_val[w] && !w_par_ok[w]) w_par_err = 1'b1;
      end
      if (force_no_match_h) w_res = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (w_res[w]) w_hit_idx = WAY_W'(w);
         if (!w_any_val[w]) begin
            w_free     = 1'b1;
            w_free_idx = WAY_W'(w);
         end
      end
   end

   always_ff @(posedge clk_csh_h or negedge mr_reset_l) begin
      if (!mr_reset_l) r_state <= ST_IDLE;
      else             r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (val_clr_all_h) w_state_nxt = ST_SWEEP;
         ST_SWEEP: if (&r_sweep_cnt)  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_csh_h or negedge mr_reset_l) begin
      if (!mr_reset_l) r_sweep_cnt <= '0;
      else if (w_sweep) r_sweep_cnt <= r_sweep_cnt + IDX_W'(1);
      else              r_sweep_cnt <= '0;
   end

   // The refill tree write is issued last so it supersedes a same-set lookup update.
   always_ff @(posedge clk_csh_h or negedge mr_reset_l) begin
      if (!mr_reset_l) begin
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               r_tag[w][s] <= '0;
               r_par[w][s] <= 1'b1;
               r_val[w][s] <= '0;
            end
         end
         for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
      end else begin
         if (w_sweep) begin
            for (int w = 0; w < WAYS; w++) r_val[w][r_sweep_cnt] <= '0;
         end else if (w_refill_ok) begin
            r_tag[refill_way_h][refill_idx_h] <= refill_tag_h;
            r_par[refill_way_h][refill_idx_h] <= ~(^refill_tag_h) ^ w_par_inj[refill_way_h];
            r_val[refill_way_h][refill_idx_h] <= refill_wd_en_h;
         end
         if (w_lru_upd)   r_plru[lookup_idx_h] <= f_touch(r_plru[lookup_idx_h], w_hit_idx);
         if (w_refill_ok) r_plru[refill_idx_h] <= f_touch(r_plru[refill_idx_h], refill_way_h);
      end
   end

   always_ff @(posedge clk_csh_h or negedge mr_reset_l) begin
      if (!mr_reset_l) begin
         hit_way_h     <= '0;
         hit_h         <= 1'b0;
         multi_hit_h   <= 1'b0;
         wd_val_h      <= '0;
         lru_way_h     <= '0;
         adr_par_bad_l <= 1'b1;
         wr_drop_h     <= 1'b0;
         diag_tag_h    <= '0;
         diag_par_h    <= 1'b0;
         diag_val_h    <= '0;
      end else begin
         wr_drop_h <= refill_wr_h && w_sweep;
         if (lookup_h) begin
            hit_way_h     <= w_res & ~(w_res - WAYS'(1));
            hit_h         <= w_hit;
            multi_hit_h   <= w_multi;
            wd_val_h      <= w_wd_val;
            lru_way_h     <= w_free ? w_free_idx : w_victim;
            adr_par_bad_l <= ~w_par_err;
         end
         if (diag_rd_h) begin
            diag_tag_h <= r_tag[diag_way_h][diag_idx_h];
            diag_par_h <= r_par[diag_way_h][diag_idx_h];
            diag_val_h <= r_val[diag_way_h][diag_idx_h];
         end
      end
   end

endmodule

// File: tb/tb_csh_dir_nway.sv
// tb/tb_csh_dir_nway.sv - self-checking bench for csh_dir_nway against a behavioural directory model
module tb_csh_dir_nway;

   localparam int SETS = 128;

   logic        clk_csh_h = 1'b0;
   logic        mr_reset_l = 1'b0;
   logic        lookup_h = 1'b0;
   logic [6:0]  lookup_idx_h = '0;
   logic [12:0] lookup_tag_h = '0;
   logic [1:0]  lookup_wd_h = '0;
   logic        force_no_match_h = 1'b0;
   logic [3:0]  force_valid_match_h = '0;
   logic        use_wr_en_h = 1'b0;
   logic        use_hold_h = 1'b0;
   logic        refill_wr_h = 1'b0;
   logic [1:0]  refill_way_h = '0;
   logic [6:0]  refill_idx_h = '0;
   logic [12:0] refill_tag_h = '0;
   logic [3:0]  refill_wd_en_h = '0;
   logic        val_clr_all_h = 1'b0;
   logic        diag_rd_h = 1'b0;
   logic [1:0]  diag_way_h = '0;
   logic [6:0]  diag_idx_h = '0;
   logic [3:0]  hit_way_h;
   logic        hit_h, multi_hit_h;
   logic [3:0]  wd_val_h;
   logic [1:0]  lru_way_h;
   logic        adr_par_bad_l, sweep_busy_h, wr_drop_h;
   logic [12:0] diag_tag_h;
   logic        diag_par_h;
   logic [3:0]  diag_val_h;

   csh_dir_nway dut (
      .clk_csh_h(clk_csh_h), .mr_reset_l(mr_reset_l),
      .lookup_h(lookup_h), .lookup_idx_h(lookup_idx_h), .lookup_tag_h(lookup_tag_h), .lookup_wd_h(lookup_wd_h),
      .force_no_match_h(force_no_match_h), .force_valid_match_h(force_valid_match_h),
      .use_wr_en_h(use_wr_en_h), .use_hold_h(use_hold_h),
      .refill_wr_h(refill_wr_h), .refill_way_h(refill_way_h), .refill_idx_h(refill_idx_h),
      .refill_tag_h(refill_tag_h), .refill_wd_en_h(refill_wd_en_h),
      .val_clr_all_h(val_clr_all_h), .diag_rd_h(diag_rd_h), .diag_way_h(diag_way_h), .diag_idx_h(diag_idx_h),
      .hit_way_h(hit_way_h), .hit_h(hit_h), .multi_hit_h(multi_hit_h), .wd_val_h(wd_val_h),
      .lru_way_h(lru_way_h), .adr_par_bad_l(adr_par_bad_l), .sweep_busy_h(sweep_busy_h),
      .wr_drop_h(wr_drop_h), .diag_tag_h(diag_tag_h), .diag_par_h(diag_par_h), .diag_val_h(diag_val_h)
   );

   always #5 clk_csh_h = ~clk_csh_h;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Directory model: plain arrays plus a 4-way tree kept as three named node bits per set.
   logic [12:0] m_tag [4][SETS];
   logic        m_par [4][SETS];
   logic [3:0]  m_val [4][SETS];
   bit          m_root [SETS], m_lft [SETS], m_rgt [SETS];
   bit          m_busy;
   int          m_cnt;
   logic [3:0]  m_inj = '0;

   logic [3:0]  e_hit_way, e_wdval, e_dval;
   logic        e_hit, e_multi, e_parl, e_busy, e_drop, e_dpar;
   logic [1:0]  e_lru;
   logic [12:0] e_dtag;

   function automatic int victim(input int s);
      if (m_root[s]) return m_rgt[s] ? 3 : 2;
      return m_lft[s] ? 1 : 0;
   endfunction

   task automatic touch(input int s, input int w);
      if (w < 2) begin
         m_root[s] = 1'b1;
         m_lft[s]  = (w == 0);
      end else begin
         m_root[s] = 1'b0;
         m_rgt[s]  = (w == 2);
      end
   endtask

   task automatic model_reset();
      for (int w = 0; w < 4; w++)
         for (int s = 0; s < SETS; s++) begin
            m_tag[w][s] = '0; m_par[w][s] = 1'b1; m_val[w][s] = '0;
         end
      for (int s = 0; s < SETS; s++) begin
         m_root[s] = 0; m_lft[s] = 0; m_rgt[s] = 0;
      end
      m_busy = 0; m_cnt = 0;
      e_hit_way = '0; e_hit = 0; e_multi = 0; e_wdval = '0; e_lru = '0; e_parl = 1;
      e_busy = 0; e_drop = 0; e_dtag = '0; e_dpar = 0; e_dval = '0;
   endtask

   task automatic model_edge();
      int li, hw, ri, fi;
      bit lupd, par_err, anyv, pok, refill_ok;
      logic [3:0] res;
      lupd = 0; li = 0; hw = -1;
      refill_ok = refill_wr_h && !m_busy;
      ri = int'(refill_idx_h);
      if (lookup_h) begin
         li = int'(lookup_idx_h);
         res = '0; par_err = 0; fi = -1;
         for (int w = 0; w < 4; w++) begin
            anyv = (m_val[w][li] != 0);
            pok  = ($countones({m_tag[w][li], m_par[w][li]}) % 2) == 1;
            if (anyv && !pok) par_err = 1;
            if ((anyv && pok && m_tag[w][li] == lookup_tag_h && !m_busy) || force_valid_match_h[w]) res[w] = 1'b1;
            e_wdval[w] = m_val[w][li][lookup_wd_h];
            if (!anyv && fi < 0) fi = w;
         end
         if (force_no_match_h) res = '0;
         for (int w = 3; w >= 0; w--) if (res[w]) hw = w;
         e_hit     = (hw >= 0);
         e_hit_way = (hw >= 0) ? 4'(1 << hw) : 4'd0;
         e_multi   = $countones(res) > 1;
         e_parl    = !par_err;
         e_lru     = 2'((fi >= 0) ? fi : victim(li));
         lupd      = e_hit && use_wr_en_h && !use_hold_h;
      end
      if (lupd && !(refill_ok && ri == li)) touch(li, hw);
      e_drop = refill_wr_h && m_busy;
      if (diag_rd_h) begin
         e_dtag = m_tag[diag_way_h][diag_idx_h];
         e_dpar = m_par[diag_way_h][diag_idx_h];
         e_dval = m_val[diag_way_h][diag_idx_h];
      end
      if (refill_ok) begin
         m_tag[refill_way_h][ri] = refill_tag_h;
         m_par[refill_way_h][ri] = (($countones(refill_tag_h) % 2) == 0) ^ m_inj[refill_way_h];
         m_val[refill_way_h][ri] = refill_wd_en_h;
         touch(ri, int'(refill_way_h));
      end
      if (m_busy) begin
         for (int w = 0; w < 4; w++) m_val[w][m_cnt] = '0;
         m_cnt++;
         if (m_cnt == SETS) m_busy = 0;
      end else if (val_clr_all_h) begin
         m_busy = 1; m_cnt = 0;
      end
      e_busy = m_busy;
   endtask

   always @(negedge clk_csh_h) begin
      if (chk_en) begin
         chk("hit_way_h", 32'(hit_way_h), 32'(e_hit_way));
         chk("hit_h", 32'(hit_h), 32'(e_hit));
         chk("multi_hit_h", 32'(multi_hit_h), 32'(e_multi));
         chk("wd_val_h", 32'(wd_val_h), 32'(e_wdval));
         chk("lru_way_h", 32'(lru_way_h), 32'(e_lru));
         chk("adr_par_bad_l", 32'(adr_par_bad_l), 32'(e_parl));
         chk("sweep_busy_h", 32'(sweep_busy_h), 32'(e_busy));
         chk("wr_drop_h", 32'(wr_drop_h), 32'(e_drop));
         chk("diag_tag_h", 32'(diag_tag_h), 32'(e_dtag));
         chk("diag_par_h", 32'(diag_par_h), 32'(e_dpar));
         chk("diag_val_h", 32'(diag_val_h), 32'(e_dval));
      end
   end

   task automatic go();
      @(posedge clk_csh_h);
      if (mr_reset_l) model_edge();
      @(negedge clk_csh_h);
      #1;
      lookup_h = 0; refill_wr_h = 0; val_clr_all_h = 0; diag_rd_h = 0;
      force_no_match_h = 0; force_valid_match_h = '0; use_wr_en_h = 0; use_hold_h = 0;
   endtask

   task automatic set_refill(input int way, input int idx, input int tag, input logic [3:0] en);
      refill_wr_h = 1; refill_way_h = 2'(way); refill_idx_h = 7'(idx);
      refill_tag_h = 13'(tag); refill_wd_en_h = en;
   endtask

   task automatic set_lookup(input int idx, input int tag, input int wd, input bit wr, input bit hold);
      lookup_h = 1; lookup_idx_h = 7'(idx); lookup_tag_h = 13'(tag);
      lookup_wd_h = 2'(wd); use_wr_en_h = wr; use_hold_h = hold;
   endtask

   task automatic set_diag(input int way, input int idx);
      diag_rd_h = 1; diag_way_h = 2'(way); diag_idx_h = 7'(idx);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cycles;
      model_reset();
      #1 chk_en = 1;
      repeat (3) @(negedge clk_csh_h);
      mr_reset_l = 1;
      #1;
      chk("reset_par_l", 32'(adr_par_bad_l), 32'd1);

      // Basic refill then lookup one cycle later.
      set_refill(2, 5, 'h1ABC, 4'b0101); go();
      set_lookup(5, 'h1ABC, 2, 0, 0); go();
      chk("t1_hit_way", 32'(hit_way_h), 32'b0100);
      chk("t1_wd_val", 32'(wd_val_h), 32'b0100);
      chk("t1_par_l", 32'(adr_par_bad_l), 32'd1);
      chk("t1_lru_free", 32'(lru_way_h), 32'd0);

      // PLRU sequence at idx 9.
      for (int w = 0; w < 4; w++) begin
         set_refill(w, 9, 'h100 + w, 4'b1111); go();
      end
      set_lookup(9, 'h101, 0, 1, 0); go();
      chk("t2_lru_a", 32'(lru_way_h), 32'd0);
      chk("t2_hit_w1", 32'(hit_way_h), 32'b0010);
      set_lookup(9, 'h100, 0, 1, 0); go();
      chk("t2_lru_b", 32'(lru_way_h), 32'd2);
      set_lookup(9, 'h103, 0, 1, 1); go();
      chk("t2_lru_hold", 32'(lru_way_h), 32'd2);
      set_lookup(9, 'h100, 0, 0, 0); go();
      chk("t2_lru_after_hold", 32'(lru_way_h), 32'd2);

      // Same-set lookup hit and refill in one cycle: refill tree update wins.
      set_lookup(9, 'h102, 0, 1, 0); set_refill(0, 9, 'h100, 4'b1111); go();
      set_lookup(9, 'h101, 0, 0, 0); go();
      chk("t2_refill_wins", 32'(lru_way_h), 32'd2);

      // Same-cycle lookup sees pre-write contents; next cycle sees the new line.
      set_lookup(40, 'h040, 0, 0, 0); set_refill(0, 40, 'h040, 4'b0001); go();
      chk("t3_prewrite_miss", 32'(hit_h), 32'd0);
      set_lookup(40, 'h040, 0, 0, 0); go();
      chk("t3_postwrite_hit", 32'(hit_way_h), 32'b0001);

      // Parity corruption on way 1.
      force dut.w_par_inj = 4'b0010;
      m_inj = 4'b0010;
      set_refill(1, 20, 'h055, 4'b0001); go();
      release dut.w_par_inj;
      m_inj = '0;
      set_lookup(20, 'h055, 0, 0, 0); go();
      chk("t4_par_l", 32'(adr_par_bad_l), 32'd0);
      chk("t4_hit", 32'(hit_h), 32'd0);
      set_diag(1, 20); go();
      chk("t4_diag_par", 32'(diag_par_h), 32'd0);
      chk("t4_diag_tag", 32'(diag_tag_h), 32'h055);

      // Multiple matches and forces.
      set_refill(1, 30, 'h777, 4'b1111); go();
      set_refill(3, 30, 'h777, 4'b1111); go();
      set_lookup(30, 'h777, 0, 0, 0); go();
      chk("t5_hit_way", 32'(hit_way_h), 32'b0010);
      chk("t5_multi", 32'(multi_hit_h), 32'd1);
      set_lookup(30, 'h777, 0, 0, 0); force_no_match_h = 1; go();
      chk("t5_fnm_hit", 32'(hit_h), 32'd0);
      set_lookup(30, 'h000, 0, 0, 0); force_valid_match_h = 4'b0001; go();
      chk("t5_fvm_way", 32'(hit_way_h), 32'b0001);

      // Valid-clear sweep.
      set_refill(2, 127, 'h0AA, 4'b1000); go();
      val_clr_all_h = 1; go();
      busy_cycles = 0;
      for (int i = 0; i < 400 && sweep_busy_h; i++) begin
         busy_cycles++;
         case (i)
            10: set_refill(0, 60, 'h3, 4'b1111);
            20: val_clr_all_h = 1;
            30: set_lookup(127, 'h0AA, 3, 0, 0);
            31: begin set_lookup(127, 'h111, 3, 0, 0); force_valid_match_h = 4'b1000; end
            default: ;
         endcase
         go();
         if (i == 10) chk("t6_drop_pulse", 32'(wr_drop_h), 32'd1);
         if (i == 11) chk("t6_drop_end", 32'(wr_drop_h), 32'd0);
         if (i == 30) chk("t6_sweep_nohit", 32'(hit_h), 32'd0);
         if (i == 31) chk("t6_sweep_fvm", 32'(hit_way_h), 32'b1000);
      end
      chk("t6_busy_cycles", 32'(busy_cycles), 32'd128);
      set_lookup(127, 'h0AA, 3, 0, 0); go();
      chk("t6_last_set_miss", 32'(hit_h), 32'd0);
      chk("t6_last_set_wdval", 32'(wd_val_h), 32'd0);
      set_lookup(5, 'h1ABC, 2, 0, 0); go();
      chk("t6_idx5_miss", 32'(hit_h), 32'd0);
      set_lookup(9, 'h100, 0, 0, 0); go();
      chk("t6_idx9_miss", 32'(hit_h), 32'd0);

      // Asynchronous reset in the middle of a sweep.
      set_refill(3, 50, 'h1234, 4'b1111); go();
      set_lookup(50, 'h1234, 1, 0, 0); set_diag(3, 50); go();
      val_clr_all_h = 1; go();
      repeat (5) go();
      #2 mr_reset_l = 0;
      #1;
      chk("t7_rst_busy", 32'(sweep_busy_h), 32'd0);
      chk("t7_rst_hit_way", 32'(hit_way_h), 32'd0);
      chk("t7_rst_hit", 32'(hit_h), 32'd0);
      chk("t7_rst_multi", 32'(multi_hit_h), 32'd0);
      chk("t7_rst_wdval", 32'(wd_val_h), 32'd0);
      chk("t7_rst_lru", 32'(lru_way_h), 32'd0);
      chk("t7_rst_par_l", 32'(adr_par_bad_l), 32'd1);
      chk("t7_rst_drop", 32'(wr_drop_h), 32'd0);
      chk("t7_rst_dtag", 32'(diag_tag_h), 32'd0);
      chk("t7_rst_dval", 32'(diag_val_h), 32'd0);
      model_reset();
      go(); go();
      mr_reset_l = 1;
      for (int k = 0; k < 4; k++) begin
         set_diag(k, (k * 41) % SETS); go();
         chk("t7_diag_tag", 32'(diag_tag_h), 32'd0);
         chk("t7_diag_par", 32'(diag_par_h), 32'd1);
         chk("t7_diag_val", 32'(diag_val_h), 32'd0);
      end
      set_diag(3, 50); go();
      chk("t7_diag_50_tag", 32'(diag_tag_h), 32'd0);

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
